// File: rtl/mem_pkg.sv
// Shared encodings and types for the byte-addressable data memory.
// Size codes follow the MEM-stage control bundle.
package mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    // Alignment rule: bytes never misalign; size 2'b11 behaves as a word.
    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic mis;
        mis = 1'b0;
        unique case (size)
            MEM_BYTE: mis = 1'b0;
            MEM_HALF: mis = lane[0];
            default:  mis = (lane != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/subword_align.sv
// Lane steering for sub-word stores and lane extraction/extension for loads.
// Purely combinational so it can be reused by a future cache.
module subword_align
    import mem_pkg::*;
(
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] lane_data_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;
    logic [15:0] half_sel;

    // Store side: byte enables and data replicated onto every lane.
    always_comb begin
        be_o        = 4'b1111;
        lane_data_o = wdata_i;
        unique case (size_i)
            MEM_BYTE: begin
                be_o        = 4'b0001 << lane_i;
                lane_data_o = {4{wdata_i[7:0]}};
            end
            MEM_HALF: begin
                be_o        = lane_i[1] ? 4'b1100 : 4'b0011;
                lane_data_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o        = 4'b1111;
                lane_data_o = wdata_i;
            end
        endcase
    end

    // Load side: bring the addressed lane(s) down to bit 0, then extend.
    always_comb begin
        shifted  = rword_i >> {lane_i, 3'b000};
        half_sel = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
        rdata_o  = rword_i;
        unique case (size_i)
            MEM_BYTE:
                rdata_o = {{24{sign_i & shifted[7]}}, shifted[7:0]};
            MEM_HALF:
                rdata_o = {{16{sign_i & half_sel[15]}}, half_sel};
            default:
                rdata_o = rword_i;
        endcase
    end

endmodule

// File: rtl/data_memory_be.sv
// Byte-addressable MEM-stage data memory with a sequential clear engine.
// The array has no reset so it can map to block RAM.
module data_memory_be
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        Misaligned,
    output logic        Out_of_range,
    output logic        Busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    clr_state_e       state_q;
    logic [IDX_W-1:0] clr_ptr_q;
    logic             busy_q;

    logic [31:0] mem_q [DEPTH];

    logic             req;
    logic             mis_raw;
    logic             oor_raw;
    logic             acc_ok;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rword;
    logic [3:0]       st_be;
    logic [31:0]      st_data;
    logic [31:0]      ld_data;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;

    assign req     = MemRead | MemWrite;
    assign idx     = Address[IDX_W+1:2];
    assign mis_raw = is_misaligned(MemSize, Address[1:0]);
    assign oor_raw = {2'b00, Address[31:2]} >= 32'(DEPTH);
    assign acc_ok  = req & ~busy_q & ~mis_raw & ~oor_raw;

    assign Busy         = busy_q;
    assign Misaligned   = req & ~busy_q & mis_raw;
    assign Out_of_range = req & ~busy_q & oor_raw;

    // Pre-edge word; only looked at when the access is in range.
    assign rword = mem_q[idx];

    subword_align u_align (
        .lane_i      (Address[1:0]),
        .size_i      (MemSize),
        .sign_i      (MemSigned),
        .wdata_i     (Write_data),
        .rword_i     (rword),
        .be_o        (st_be),
        .lane_data_o (st_data),
        .rdata_o     (ld_data)
    );

    assign Read_data = (acc_ok & MemRead) ? ld_data : 32'h0;

    // Clear FSM: walk every word once after reset, then stay ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    if (clr_ptr_q == LAST_IDX) begin
                        state_q   <= READY;
                        clr_ptr_q <= '0;
                        busy_q    <= 1'b0;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= READY;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Single write port shared by the clear engine and real stores.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = idx;
        wr_be   = st_be;
        wr_data = st_data;
        if (state_q == CLEAR) begin
            wr_en   = ~reset;
            wr_idx  = clr_ptr_q;
            wr_be   = 4'b1111;
            wr_data = 32'h0;
        end else if (acc_ok & MemWrite) begin
            wr_en = ~reset;
        end
    end

    // Byte-enabled array write, no reset on the storage itself.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule
